instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Control-unit stage directly downstream of `memory`: consumes `opcodeOut`/`dataOut` and produces every control strobe for the 4-bit CPU.
- Strobes driven: memory (`Laddr`, `Eram`, `WE`, `Esp`, `spOp`), program counter, accumulator/B register, ALU, output register.
- Internally: instruction register (IR) plus a T-state step FSM (fetch, decode, variable-length execute).

Parameters:
- CW_W, 16, control-word width (bit layout fixed in package)
- MAX_STEP, 5, last legal T-state index (T0..T5)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- step_en  in  1  advance enable; low freezes FSM and forces ctrl=0
- opcode_in  in  4  from memory opcodeOut
- data_in  in  4  from memory dataOut
- zero_flag  in  1  ALU zero flag, sampled in T2 of JZ
- ctrl  out  16  control word: b0 Cpc, b1 Epc, b2 Lpc, b3 Laddr, b4 Eram, b5 WE, b6 Eir, b7 Esp, b9:8 spOp, b10 La, b11 Ea, b12 Lb, b13 Eu, b14 Su, b15 Lo
- ir_operand  out  4  IR low nibble, driven to bus when Eir
- step  out  3  current T-state
- halted  out  1  high in HALT

Behaviour:
Reset:
- While reset is high: step=0, IR=8'h00, halted=0, ctrl=0.
- First cycle after deassertion is T0.

State encoding and fetch:
- States: T0..T5 plus HALT.
- ctrl is a combinational (Moore) function of {step, IR opcode, zero_flag}.
- T0: Epc|Laddr.
- T1: Eram|Cpc. IR <= {opcode_in, data_in} on the T1→T2 edge.
- T2..: execute per opcode (below). After an instruction's last step, next state is T0.

Execute steps (spOp: 00 HOLD, 01 INC, 10 DEC, 11 RST):
- NOP 0000 / undefined: T2 ctrl=0.
- LDA 0001: T2 Eir|Laddr. T3 Eram|La.
- ADD 0010: T2 Eir|Laddr. T3 Eram|Lb. T4 Eu|La.
- SUB 0011: as ADD, but T4 Eu|Su|La.
- STA 0100: T2 Eir|Laddr. T3 Ea|WE.
- OUT 0101: T2 Ea|Lo.
- JMP 0110: T2 Eir|Lpc.
- JZ 0111: T2 Eir|Lpc if zero_flag=1, else ctrl=0.
- PUSH 1000: T2 spOp=DEC. T3 Esp|Ea|WE.
- POP 1001: T2 Esp|Eram|La. T3 spOp=INC.
- HLT 1111: T2 ctrl=0, then HALT.

Latency (instruction length):
- 3 cycles: NOP, OUT, JMP, JZ, HLT.
- 4 cycles: LDA, STA, PUSH, POP.
- 5 cycles: ADD, SUB.

Edge cases:
- HALT: ctrl=0, halted=1. Exits only via reset.
- step_en=0: state, IR and step hold; ctrl=0. Resuming re-issues the held step's strobes exactly once.
- Reset mid-instruction: immediate return to reset values. The partial instruction is abandoned.
- Invariants:
  - WE and Eram are never both high.
  - At most one bus driver active per cycle (Epc, Eram, Eir, Ea, Eu, Esp-read).
- step never exceeds MAX_STEP. An illegal step value recovers to T0 next cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - control-word bit indices (CW_CPC..CW_LO);
  - spOp codes (SP_HOLD, SP_INC, SP_DEC, SP_RST);
  - T-state encodings.
- One sub-module, `microcode_rom`: purely combinational {step, opcode, zero_flag} → ctrl.
- instr_sequencer keeps the IR, step counter, halt and step_en logic.

Test Plan:
- Reset, then step_en=1; memory returns opcode 0001, data 0011 → T0 ctrl=16'h000A; T1 ctrl=16'h0011; IR=8'h13; T2 ctrl=16'h0048; T3 ctrl=16'h0410; next cycle step=0.
- ADD (0010) → 5-cycle cycle; T4 ctrl=16'h2400. SUB (0011) → T4 ctrl=16'h6400.
- JZ 0111 operand 1010:
  - with zero_flag=1 → T2 ctrl=16'h0044;
  - with zero_flag=0 → T2 ctrl=0;
  - both return to T0.
- PUSH then POP:
  - PUSH → T2 spOp=2'b10; T3 ctrl=16'h08A0.
  - POP → T2 ctrl=16'h0490; T3 spOp=2'b01.
  - Assert WE&Eram never both high.
- HLT:
  - halted=1 from the cycle after T2; ctrl=0 for 10 cycles.
  - reset pulse mid-HALT → halted=0, step=0.
- step_en low during ADD T3 for 4 cycles → ctrl=0 and step=3 held; on release T3 strobes issue once; asserting reset during T4 clears IR to 8'h00 asynchronously.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, control-word layout and T-state encodings
package cpu_ctrl_pkg;

  localparam int CW_W     = 16;
  localparam int MAX_STEP = 5;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_STA  = 4'b0100;
  localparam logic [3:0] OP_OUT  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_JZ   = 4'b0111;
  localparam logic [3:0] OP_PUSH = 4'b1000;
  localparam logic [3:0] OP_POP  = 4'b1001;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam int CW_CPC   = 0;
  localparam int CW_EPC   = 1;
  localparam int CW_LPC   = 2;
  localparam int CW_LADDR = 3;
  localparam int CW_ERAM  = 4;
  localparam int CW_WE    = 5;
  localparam int CW_EIR   = 6;
  localparam int CW_ESP   = 7;
  localparam int CW_SPOP  = 8;
  localparam int CW_LA    = 10;
  localparam int CW_EA    = 11;
  localparam int CW_LB    = 12;
  localparam int CW_EU    = 13;
  localparam int CW_SU    = 14;
  localparam int CW_LO    = 15;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;
  localparam logic [1:0] SP_RST  = 2'b11;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  // Index of the final execute step; undefined opcodes behave as NOP.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA, OP_PUSH, OP_POP: last_step = T3;
      OP_ADD, OP_SUB:                  last_step = T4;
      default:                         last_step = T2;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - memory-side inputs and control outputs of the sequencer
interface instr_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic            step_en;
  logic [3:0]      opcode_in;
  logic [3:0]      data_in;
  logic            zero_flag;
  logic [CW_W-1:0] ctrl;
  logic [3:0]      ir_operand;
  logic [2:0]      step;
  logic            halted;

  modport master (
    output step_en, opcode_in, data_in, zero_flag,
    input  ctrl, ir_operand, step, halted
  );

  modport slave (
    input  step_en, opcode_in, data_in, zero_flag,
    output ctrl, ir_operand, step, halted
  );

endinterface

// File: rtl/instr_sequencer_rom.sv
// rtl/instr_sequencer_rom.sv - combinational microcode: {step, opcode, zero_flag} to control word
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0]      step_i,
  input  logic [3:0]      opcode_i,
  input  logic            zero_flag_i,
  output logic [CW_W-1:0] ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (step_i)
      T0: begin
        ctrl_o[CW_EPC]   = 1'b1;
        ctrl_o[CW_LADDR] = 1'b1;
      end
      T1: begin
        ctrl_o[CW_ERAM] = 1'b1;
        ctrl_o[CW_CPC]  = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o[CW_EIR]   = 1'b1;
            ctrl_o[CW_LADDR] = 1'b1;
          end
          OP_OUT: begin
            ctrl_o[CW_EA] = 1'b1;
            ctrl_o[CW_LO] = 1'b1;
          end
          OP_JMP: begin
            ctrl_o[CW_EIR] = 1'b1;
            ctrl_o[CW_LPC] = 1'b1;
          end
          OP_JZ: begin
            ctrl_o[CW_EIR] = zero_flag_i;
            ctrl_o[CW_LPC] = zero_flag_i;
          end
          OP_PUSH: ctrl_o[CW_SPOP +: 2] = SP_DEC;
          OP_POP: begin
            ctrl_o[CW_ESP]  = 1'b1;
            ctrl_o[CW_ERAM] = 1'b1;
            ctrl_o[CW_LA]   = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o[CW_ERAM] = 1'b1;
            ctrl_o[CW_LA]   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o[CW_ERAM] = 1'b1;
            ctrl_o[CW_LB]   = 1'b1;
          end
          OP_STA: begin
            ctrl_o[CW_EA] = 1'b1;
            ctrl_o[CW_WE] = 1'b1;
          end
          OP_PUSH: begin
            ctrl_o[CW_ESP] = 1'b1;
            ctrl_o[CW_EA]  = 1'b1;
            ctrl_o[CW_WE]  = 1'b1;
          end
          OP_POP:  ctrl_o[CW_SPOP +: 2] = SP_INC;
          default: ctrl_o = '0;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o[CW_EU] = 1'b1;
          ctrl_o[CW_LA] = 1'b1;
          ctrl_o[CW_SU] = (opcode_i == OP_SUB);
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction register, T-state step counter and halt control
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STEP_P = MAX_STEP
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  logic [2:0]      step_q, step_d;
  logic [7:0]      ir_q, ir_d;
  logic            halted_q, halted_d;
  logic [CW_W-1:0] rom_ctrl;
  logic            step_legal;
  logic            advance;

  assign step_legal = (step_q <= 3'(MAX_STEP_P));
  assign advance    = bus.step_en && !halted_q;

  microcode_rom u_rom (
    .step_i      (step_q),
    .opcode_i    (ir_q[7:4]),
    .zero_flag_i (bus.zero_flag),
    .ctrl_o      (rom_ctrl)
  );

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (!step_legal) begin
      step_d = T0;
    end else if (advance) begin
      if (step_q == T1)
        ir_d = {bus.opcode_in, bus.data_in};
      // The IR is only meaningful from T2 on, so instruction length is checked there.
      if (step_q >= T2 && step_q == last_step(ir_q[7:4])) begin
        step_d   = T0;
        halted_d = (ir_q[7:4] == OP_HLT);
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign bus.ctrl       = (advance && step_legal && !reset) ? rom_ctrl : '0;
  assign bus.ir_operand = ir_q[3:0];
  assign bus.step       = step_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.step_en = 1'b1;
    bus.opcode_in = 4'h0;
    bus.data_in = 4'h0;
    bus.zero_flag = 1'b0;
    cycle();
    cycle();
    n_vec++;
    if (bus.step !== 3'd0) begin n_err++; $display("FAIL reset_step actual=%0d required=0", bus.step); end
    n_vec++;
    if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted actual=%b required=0", bus.halted); end
    n_vec++;
    if (bus.ctrl !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl actual=%h required=0000", bus.ctrl); end
    n_vec++;
    if (bus.ir_operand !== 4'h0) begin n_err++; $display("FAIL reset_ir actual=%h required=0", bus.ir_operand); end
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.ctrl !== 16'h000A) begin n_err++; $display("FAIL reset_t0_ctrl actual=%h required=000a", bus.ctrl); end
  endtask

  task automatic test_lda();
    logic [15:0] exp [4];
    exp = '{16'h000A, 16'h0011, 16'h0048, 16'h0410};
    bus.opcode_in = 4'b0001;
    bus.data_in = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.step !== 3'(i) || bus.ctrl !== exp[i]) begin
        n_err++;
        $display("FAIL lda_t%0d actual step=%0d ctrl=%h required step=%0d ctrl=%h", i, bus.step, bus.ctrl, i, exp[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (bus.ir_operand !== 4'h3) begin n_err++; $display("FAIL lda_ir actual=%h required=3", bus.ir_operand); end
      end
      cycle();
    end
    n_vec++;
    if (bus.step !== 3'd0) begin n_err++; $display("FAIL lda_wrap actual=%0d required=0", bus.step); end
  endtask

  task automatic test_add_sub();
    logic [15:0] exp [5];
    logic [3:0]  ops [2];
    logic [15:0] t4 [2];
    ops = '{4'b0010, 4'b0011};
    t4 = '{16'h2400, 16'h6400};
    for (int k = 0; k < 2; k++) begin
      exp = '{16'h000A, 16'h0011, 16'h0048, 16'h1010, t4[k]};
      bus.opcode_in = ops[k];
      bus.data_in = 4'h7;
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (bus.step !== 3'(i) || bus.ctrl !== exp[i]) begin
          n_err++;
          $display("FAIL addsub_op%0d_t%0d actual step=%0d ctrl=%h required step=%0d ctrl=%h", ops[k], i, bus.step, bus.ctrl, i, exp[i]);
        end
        cycle();
      end
      n_vec++;
      if (bus.step !== 3'd0) begin n_err++; $display("FAIL addsub_wrap actual=%0d required=0", bus.step); end
    end
  endtask

  task automatic test_jz();
    logic [15:0] t2 [2];
    t2 = '{16'h0044, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      bus.opcode_in = 4'b0111;
      bus.data_in = 4'b1010;
      bus.zero_flag = (k == 0);
      cycle();
      cycle();
      n_vec++;
      if (bus.step !== 3'd2 || bus.ctrl !== t2[k]) begin
        n_err++;
        $display("FAIL jz_z%0d_t2 actual step=%0d ctrl=%h required step=2 ctrl=%h", (k == 0), bus.step, bus.ctrl, t2[k]);
      end
      cycle();
      n_vec++;
      if (bus.step !== 3'd0) begin n_err++; $display("FAIL jz_wrap actual=%0d required=0", bus.step); end
    end
    bus.zero_flag = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [15:0] exp [2][4];
    logic [3:0]  ops [2];
    ops = '{4'b1000, 4'b1001};
    exp[0] = '{16'h000A, 16'h0011, 16'h0200, 16'h08A0};
    exp[1] = '{16'h000A, 16'h0011, 16'h0490, 16'h0100};
    for (int k = 0; k < 2; k++) begin
      bus.opcode_in = ops[k];
      bus.data_in = 4'h0;
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (bus.ctrl !== exp[k][i]) begin
          n_err++;
          $display("FAIL stack_op%0d_t%0d actual=%h required=%h", ops[k], i, bus.ctrl, exp[k][i]);
        end
        n_vec++;
        if (bus.ctrl[5] & bus.ctrl[4]) begin
          n_err++;
          $display("FAIL we_eram_excl actual=11 required=not both");
        end
        cycle();
      end
      n_vec++;
      if (bus.step !== 3'd0) begin n_err++; $display("FAIL stack_wrap actual=%0d required=0", bus.step); end
    end
  endtask

  task automatic test_step_en();
    bus.opcode_in = 4'b0010;
    bus.data_in = 4'h5;
    cycle();
    cycle();
    cycle();
    n_vec++;
    if (bus.step !== 3'd3 || bus.ir_operand !== 4'h5) begin
      n_err++;
      $display("FAIL stall_entry actual step=%0d ir=%h required step=3 ir=5", bus.step, bus.ir_operand);
    end
    bus.step_en = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.step !== 3'd3 || bus.ctrl !== 16'h0000) begin
        n_err++;
        $display("FAIL stall_hold%0d actual step=%0d ctrl=%h required step=3 ctrl=0000", i, bus.step, bus.ctrl);
      end
      cycle();
    end
    bus.step_en = 1'b1;
    #1;
    n_vec++;
    if (bus.step !== 3'd3 || bus.ctrl !== 16'h1010) begin
      n_err++;
      $display("FAIL stall_resume actual step=%0d ctrl=%h required step=3 ctrl=1010", bus.step, bus.ctrl);
    end
    cycle();
    n_vec++;
    if (bus.step !== 3'd4 || bus.ctrl !== 16'h2400) begin
      n_err++;
      $display("FAIL stall_t4 actual step=%0d ctrl=%h required step=4 ctrl=2400", bus.step, bus.ctrl);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.ir_operand !== 4'h0 || bus.step !== 3'd0 || bus.ctrl !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset actual ir=%h step=%0d ctrl=%h required ir=0 step=0 ctrl=0000", bus.ir_operand, bus.step, bus.ctrl);
    end
    cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_halt();
    bus.opcode_in = 4'b1111;
    bus.data_in = 4'h0;
    cycle();
    cycle();
    n_vec++;
    if (bus.step !== 3'd2 || bus.ctrl !== 16'h0000 || bus.halted !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_t2 actual step=%0d ctrl=%h halted=%b required step=2 ctrl=0000 halted=0", bus.step, bus.ctrl, bus.halted);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_vec++;
      if (bus.halted !== 1'b1 || bus.ctrl !== 16'h0000) begin
        n_err++;
        $display("FAIL halted%0d actual halted=%b ctrl=%h required halted=1 ctrl=0000", i, bus.halted, bus.ctrl);
      end
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.halted !== 1'b0 || bus.step !== 3'd0) begin
      n_err++;
      $display("FAIL halt_reset actual halted=%b step=%0d required halted=0 step=0", bus.halted, bus.step);
    end
    cycle();
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.ctrl !== 16'h000A) begin n_err++; $display("FAIL halt_restart actual=%h required=000a", bus.ctrl); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_lda();
    test_add_sub();
    test_jz();
    test_push_pop();
    test_step_en();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
